if_id_buf: RTL and testbench

IF_ID_BUF -- requirements
Module: if_id_buf

---
 rtl/if_id_buf_pkg.sv | 12 +
 rtl/if_id_buf_fifo2_reg.sv | 34 +++
 rtl/if_id_buf.sv | 72 +++++++
 tb/tb_if_id_buf.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/if_id_buf_pkg.sv
// Shared pipeline constants and the packed IF/ID entry layout.
package if_id_buf_pkg;
    localparam int PIPE_XLEN = 32;
    localparam int DROP_W    = 8;
    localparam logic [PIPE_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] instr;
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] pc_plus4;
    } entry_t;
endpackage

// File: rtl/if_id_buf_fifo2_reg.sv
// Two-entry register storage with 1-bit wrap pointers; head is read straight from storage.
// Zero-cycle read of the head, written data visible next cycle; caller gates wr/rd.
module fifo2_reg #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] wr_dat,
    output logic [W-1:0] head_dat
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (rd_en) rd_ptr <= ~rd_ptr;
        end
    end

    // Storage is deliberately unreset; validity lives in the owner's count.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// File: rtl/if_id_buf.sv
// IF/ID skid buffer: 2-entry FIFO between fetch and decode, flush-aware with drop counter.
// One cycle fetch->decode latency; ReadyF drops only when full, independent of StallD.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int XLEN  = PIPE_XLEN,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   InstrF,
    input  logic [XLEN-1:0]   PCF,
    input  logic [XLEN-1:0]   PCPlus4F,
    input  logic              ValidF,
    output logic              ReadyF,
    input  logic              StallD,
    input  logic              FlushD,
    output logic [XLEN-1:0]   InstrD,
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D,
    output logic              ValidD,
    output logic [DROP_W-1:0] DropCnt
);
    logic [1:0]        count;
    logic              enq;
    logic              deq;
    entry_t            wr_entry;
    entry_t            head;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_next;

    assign ReadyF = (count < 2'(DEPTH));
    assign ValidD = (count != 2'd0);
    assign enq    = ValidF && ReadyF && !FlushD;
    assign deq    = ValidD && !StallD && !FlushD;

    assign wr_entry = '{instr: InstrF, pc: PCF, pc_plus4: PCPlus4F};

    fifo2_reg #(.W($bits(entry_t))) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clr      (FlushD),
        .wr_en    (enq),
        .rd_en    (deq),
        .wr_dat   (wr_entry),
        .head_dat (head)
    );

    // Saturating accumulate of entries lost to a flush.
    assign drop_sum  = {1'b0, DropCnt} + {{(DROP_W-1){1'b0}}, count};
    assign drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= 2'd0;
            DropCnt <= '0;
        end else if (FlushD) begin
            count   <= 2'd0;
            DropCnt <= drop_next;
        end else begin
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign InstrD   = ValidD ? head.instr    : NOP_INSTR;
    assign PCD      = ValidD ? head.pc       : '0;
    assign PCPlus4D = ValidD ? head.pc_plus4 : '0;
endmodule

// File: tb/tb_if_id_buf.sv
// Directed vector table plus a queue scoreboard tracking every cycle of the IF/ID buffer.
module tb_if_id_buf;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        ValidF, ReadyF, StallD, FlushD, ValidD;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic [7:0]  DropCnt;

    if_id_buf dut (
        .clk(clk), .reset(reset), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .ValidF(ValidF), .ReadyF(ReadyF), .StallD(StallD), .FlushD(FlushD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .DropCnt(DropCnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct {
        logic v, s, f;
        logic [31:0] instr, pc;
        logic e_valid, e_ready;
        logic [31:0] e_instr;
        logic [7:0]  e_drop;
    } vec_t;

    ent_t  sb_q[$];
    int    exp_drop = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    vec_t  tbl[18];

    function automatic vec_t mk(logic v, logic s, logic f, logic [31:0] instr, logic [31:0] pc,
                                logic ev, logic er, logic [31:0] ei, logic [7:0] ed);
        vec_t r;
        r.v = v; r.s = s; r.f = f; r.instr = instr; r.pc = pc;
        r.e_valid = ev; r.e_ready = er; r.e_instr = ei; r.e_drop = ed;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Compare every output against the scoreboard head.
    task automatic sb_check();
        logic        ev;
        logic [31:0] ei, ep, ep4;
        ev  = (sb_q.size() != 0);
        ei  = ev ? sb_q[0].instr : 32'h0000_0013;
        ep  = ev ? sb_q[0].pc : 32'h0;
        ep4 = ev ? sb_q[0].pc + 32'd4 : 32'h0;
        chk("sb", {ValidD, ReadyF, InstrD, PCD, PCPlus4D, DropCnt},
                  {ev, (sb_q.size() < 2), ei, ep, ep4, 8'(exp_drop)});
    endtask

    task automatic cyc(input logic rst_n, input logic v, input logic s, input logic f,
                       input logic [31:0] instr, input logic [31:0] pc);
        bit do_enq, do_deq;
        ent_t e;
        reset = rst_n; ValidF = v; StallD = s; FlushD = f;
        InstrF = instr; PCF = pc; PCPlus4F = pc + 32'd4;
        do_enq = v && (sb_q.size() < 2) && !f;
        do_deq = (sb_q.size() != 0) && !s && !f;
        @(posedge clk);
        if (!rst_n) begin
            sb_q.delete();
            exp_drop = 0;
        end else if (f) begin
            exp_drop = (exp_drop + sb_q.size() > 255) ? 255 : exp_drop + sb_q.size();
            sb_q.delete();
        end else begin
            if (do_deq) void'(sb_q.pop_front());
            if (do_enq) begin
                e.instr = instr; e.pc = pc;
                sb_q.push_back(e);
            end
        end
        @(negedge clk);
        sb_check();
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,32'h0050_0093,32'h100, 1,1,32'h0050_0093,0);
        tbl[1]  = mk(0,1,0,32'h0,32'h0,           1,1,32'h0050_0093,0);
        tbl[2]  = mk(0,0,0,32'h0,32'h0,           0,1,32'h13,0);
        tbl[3]  = mk(1,1,0,32'h11,32'h0,          1,1,32'h11,0);
        tbl[4]  = mk(1,1,0,32'h22,32'h4,          1,0,32'h11,0);
        tbl[5]  = mk(1,1,0,32'h33,32'h8,          1,0,32'h11,0);
        tbl[6]  = mk(0,0,0,32'h0,32'h0,           1,1,32'h22,0);
        tbl[7]  = mk(0,0,0,32'h0,32'h0,           0,1,32'h13,0);
        tbl[8]  = mk(1,0,0,32'h44,32'hC,          1,1,32'h44,0);
        tbl[9]  = mk(1,0,0,32'h55,32'h10,         1,1,32'h55,0);
        tbl[10] = mk(1,1,0,32'h66,32'h14,         1,0,32'h55,0);
        tbl[11] = mk(1,0,0,32'h77,32'h18,         1,1,32'h66,0);
        tbl[12] = mk(1,1,0,32'h88,32'h1C,         1,0,32'h66,0);
        tbl[13] = mk(1,1,1,32'h99,32'h20,         0,1,32'h13,2);
        tbl[14] = mk(0,0,0,32'h0,32'h0,           0,1,32'h13,2);
        tbl[15] = mk(1,0,1,32'hAA,32'h24,         0,1,32'h13,2);
        tbl[16] = mk(1,0,0,32'hBB,32'h28,         1,1,32'hBB,2);
        tbl[17] = mk(0,1,1,32'h0,32'h0,           0,1,32'h13,3);

        // Reset held two cycles while fetch offers an instruction.
        cyc(0,1,0,0,32'hDEAD_BEEF,32'h40);
        cyc(0,1,0,0,32'hDEAD_BEEF,32'h40);
        chk("reset_state", {ValidD, ReadyF, InstrD, DropCnt}, {1'b1 ^ 1'b1, 1'b1, 32'h13, 8'h0});

        foreach (tbl[i]) begin
            cyc(1, tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].instr, tbl[i].pc);
            chk($sformatf("vec%0d", i), {ValidD, ReadyF, InstrD, DropCnt},
                {tbl[i].e_valid, tbl[i].e_ready, tbl[i].e_instr, tbl[i].e_drop});
        end

        // Repeated full flushes drive DropCnt into saturation.
        for (int i = 0; i < 130; i++) begin
            cyc(1,1,1,0,32'h1000 + i,32'h200);
            cyc(1,1,1,0,32'h2000 + i,32'h204);
            cyc(1,1,1,1,32'h3000,32'h208);
        end
        chk("drop_sat", {24'h0, DropCnt}, 32'd255);
        cyc(1,1,1,0,32'h4000,32'h300);
        cyc(1,1,1,0,32'h4004,32'h304);
        chk("full_before_flush", {ValidD, ReadyF, InstrD}, {1'b1, 1'b0, 32'h4000});
        cyc(1,1,1,1,32'h4008,32'h308);
        chk("drop_hold_255", {ValidD, InstrD, DropCnt}, {1'b0, 32'h13, 8'd255});

        // Reset beats flush/stall/valid while full.
        cyc(1,1,1,0,32'h5000,32'h400);
        cyc(1,1,1,0,32'h5004,32'h404);
        cyc(0,1,1,1,32'h5008,32'h408);
        chk("reset_full", {ValidD, ReadyF, InstrD, PCD, DropCnt}, {1'b0, 1'b1, 32'h13, 32'h0, 8'h0});
        cyc(1,0,0,0,32'h0,32'h0);
        chk("post_reset_idle", {ValidD, ReadyF, DropCnt}, {1'b0, 1'b1, 8'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
